// File: rtl/bk_mw_pkg.sv
// Shared definitions for the multiword Brent-Kung adder: FSM states, slice width
// and the slice-counter width helper.
package bk_mw_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mw_state_e;

  // Counter width for n slices; never narrower than one bit so NWORDS=1 still has a counter.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/bk16.sv
// 16-bit Brent-Kung parallel-prefix adder with carry-in; exposes bitwise
// propagate/generate so callers can recover the carry into the top bit.
module bk16 (
  input  logic [15:0] x1,
  input  logic [15:0] x2,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout,
  output logic [15:0] p_out,
  output logic [15:0] g_out
);

  logic [15:0] g_pre_s;
  logic [15:0] p_pre_s;

  // Prefix tree: up-sweep builds power-of-two groups, down-sweep fills the gaps.
  always_comb begin
    g_pre_s    = x1 & x2;
    p_pre_s    = x1 ^ x2;
    g_pre_s[0] = g_pre_s[0] | (p_pre_s[0] & cin);
    for (int step = 2; step <= 16; step = step * 2) begin
      for (int i = step - 1; i < 16; i = i + step) begin
        g_pre_s[i] = g_pre_s[i] | (p_pre_s[i] & g_pre_s[i - step / 2]);
        p_pre_s[i] = p_pre_s[i] & p_pre_s[i - step / 2];
      end
    end
    for (int step = 8; step >= 2; step = step / 2) begin
      for (int i = step - 1 + step / 2; i < 16; i = i + step) begin
        g_pre_s[i] = g_pre_s[i] | (p_pre_s[i] & g_pre_s[i - step / 2]);
        p_pre_s[i] = p_pre_s[i] & p_pre_s[i - step / 2];
      end
    end
  end

  assign p_out = x1 ^ x2;
  assign g_out = x1 & x2;
  assign s     = p_out ^ {g_pre_s[14:0], cin};
  assign cout  = g_pre_s[15];

endmodule

// File: rtl/bk_multiword_adder.sv
// Sequential NWORDS x 16-bit adder: one bk16 slice per cycle with a registered
// ripple carry. Optional zero/ovf flags are enabled by defining MWADD_FLAGS_EN.
module bk_multiword_adder
  import bk_mw_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [16*NWORDS-1:0]    a_in,
  input  logic [16*NWORDS-1:0]    b_in,
  input  logic                    cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [16*NWORDS-1:0]    sum,
  output logic                    cout
`ifdef MWADD_FLAGS_EN
  ,
  output logic                    zero,
  output logic                    ovf
`endif
);

  localparam int W  = SLICE_W * NWORDS;
  localparam int KW = clog2(NWORDS);
  localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

  mw_state_e state_r;
  mw_state_e state_next_s;

  logic [W-1:0]         a_r;
  logic [W-1:0]         b_r;
  logic [W-1:0]         sum_r;
  logic                 carry_r;
  logic [KW-1:0]        k_r;

  logic [SLICE_W-1:0]   slice_s;
  logic                 slice_cout_s;
  logic [SLICE_W-1:0]   p_s;
  logic [SLICE_W-1:0]   g_s;
  logic [W+SLICE_W-1:0] sum_cat_s;
  logic                 unused_sink;

  bk16 u_bk16 (
    .x1    (a_r[SLICE_W-1:0]),
    .x2    (b_r[SLICE_W-1:0]),
    .cin   (carry_r),
    .s     (slice_s),
    .cout  (slice_cout_s),
    .p_out (p_s),
    .g_out (g_s)
  );

  // New slice enters at the top; after NWORDS shifts word k sits at position k.
  assign sum_cat_s   = {slice_s, sum_r};
  assign unused_sink = ^{g_s, p_s, sum_cat_s[SLICE_W-1:0]};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_next_s = RUN;
        else          state_next_s = IDLE;
      end
      RUN: begin
        if (k_r == K_LAST) state_next_s = DONE;
        else               state_next_s = RUN;
      end
      DONE: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Operand shift registers, sum accumulator, ripple carry and slice counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      sum_r   <= {W{1'b0}};
      carry_r <= 1'b0;
      k_r     <= {KW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a_in;
            b_r     <= b_in;
            carry_r <= cin;
            k_r     <= {KW{1'b0}};
          end
        end
        RUN: begin
          sum_r   <= sum_cat_s[W+SLICE_W-1:SLICE_W];
          carry_r <= slice_cout_s;
          a_r     <= a_r >> SLICE_W;
          b_r     <= b_r >> SLICE_W;
          k_r     <= k_r + KW'(1);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MWADD_FLAGS_EN
  logic zero_r;
  logic ovf_r;

  // Zero is an AND of per-slice zero tests; overflow compares carries into and out of bit W-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            zero_r <= 1'b1;
            ovf_r  <= 1'b0;
          end
        end
        RUN: begin
          zero_r <= zero_r & (slice_s == {SLICE_W{1'b0}});
          if (k_r == K_LAST) ovf_r <= (p_s[SLICE_W-1] ^ slice_s[SLICE_W-1]) ^ slice_cout_s;
        end
        default: begin
        end
      endcase
    end
  end

  assign zero = zero_r;
  assign ovf  = ovf_r;
`endif

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign sum       = sum_r;
  assign cout      = carry_r;

endmodule

// File: tb/tb_bk_multiword_adder.sv
// Directed self-checking bench for bk_multiword_adder (NWORDS=4 and NWORDS=1).
// Flag checks are compiled in when MWADD_FLAGS_EN is defined.
module tb_bk_multiword_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;

  logic        v1;
  logic        rdy1;
  logic [15:0] a1;
  logic [15:0] b1;
  logic        c1;
  logic        ov1;
  logic        or1;
  logic [15:0] s1;
  logic        co1;

`ifdef MWADD_FLAGS_EN
  logic zero;
  logic ovf;
  logic z1;
  logic of1;
`endif

  int checks;
  int errors;

  bk_multiword_adder #(.NWORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef MWADD_FLAGS_EN
    ,
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  bk_multiword_adder #(.NWORDS(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1),
    .in_ready  (rdy1),
    .a_in      (a1),
    .b_in      (b1),
    .cin       (c1),
    .out_valid (ov1),
    .out_ready (or1),
    .sum       (s1),
    .cout      (co1)
`ifdef MWADD_FLAGS_EN
    ,
    .zero      (z1),
    .ovf       (of1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for out_valid on the 4-word DUT; called #1 after the accept edge.
  task automatic wait_out(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic c, input logic [63:0] exp_sum, input logic exp_cout);
    int cycles;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    a_in     = a;
    b_in     = b;
    cin      = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out(cycles);
    check({tag, "_latency"}, 64'(cycles), 64'd4);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
`ifdef MWADD_FLAGS_EN
    check({tag, "_zero"}, 64'(zero), 64'(exp_sum == 64'd0));
    check({tag, "_ovf"}, 64'(ovf), 64'((a[63] == b[63]) && (exp_sum[63] != a[63])));
`endif
    @(posedge clk);
    #1;
    check({tag, "_released"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int          cycles;
    logic [63:0] held;
    logic [63:0] ra;
    logic [63:0] rb;
    logic        rc;
    logic [64:0] model;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_in      = 64'd0;
    b_in      = 64'd0;
    cin       = 1'b0;
    out_ready = 1'b1;
    v1        = 1'b0;
    a1        = 16'd0;
    b1        = 16'd0;
    c1        = 1'b0;
    or1       = 1'b1;

    #3;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
`ifdef MWADD_FLAGS_EN
    check("rst_zero", 64'(zero), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    do_op("allones_p1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1);
    do_op("max_pos_p1", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0);
    do_op("cin_chain", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 64'h0, 1'b1);
    do_op("alt_words", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0,
          64'h0001_0000_0001_0000, 1'b0);
    do_op("min_neg_x2", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1);
    do_op("ones_ones_c", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    // Output backpressure with new operands waiting on the input.
    out_ready = 1'b0;
    @(negedge clk);
    a_in     = 64'h1111_1111_1111_1111;
    b_in     = 64'h2222_2222_2222_2222;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out(cycles);
    check("bp_latency", 64'(cycles), 64'd4);
    check("bp_sum", sum, 64'h3333_3333_3333_3333);
    held     = sum;
    a_in     = 64'hAAAA_AAAA_AAAA_AAAA;
    b_in     = 64'h5555_5555_5555_5555;
    cin      = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_sum", sum, held);
      check("bp_hold_in_ready", 64'(in_ready), 64'd0);
      check("bp_hold_out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_handshake_out_valid", 64'(out_valid), 64'd0);
    check("bp_handshake_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    check("bp_accepted", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    wait_out(cycles);
    check("bp2_latency", 64'(cycles), 64'd4);
    check("bp2_sum", sum, 64'h0);
    check("bp2_cout", 64'(cout), 64'd1);
    @(posedge clk);
    #1;

    // Random back-to-back operations against an unsigned 65-bit model.
    for (int i = 0; i < 6; i++) begin
      ra    = {$urandom, $urandom};
      rb    = {$urandom, $urandom};
      rc    = 1'($urandom_range(0, 1));
      model = {1'b0, ra} + {1'b0, rb} + 65'(rc);
      do_op("rand", ra, rb, rc, model[63:0], model[64]);
    end

    // Reset while slice k=2 is pending.
    @(negedge clk);
    a_in     = 64'hFFFF_FFFF_FFFF_FFFF;
    b_in     = 64'h1;
    cin      = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", sum, 64'd0);
    check("midrst_cout", 64'(cout), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post_rst", 64'h1, 64'h1, 1'b0, 64'h2, 1'b0);

    // Single-slice configuration.
    @(negedge clk);
    check("w1_in_ready", 64'(rdy1), 64'd1);
    a1 = 16'hFFFF;
    b1 = 16'h0001;
    c1 = 1'b0;
    v1 = 1'b1;
    @(posedge clk);
    #1;
    v1     = 1'b0;
    cycles = 0;
    while (ov1 !== 1'b1 && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("w1_latency", 64'(cycles), 64'd1);
    check("w1_sum", 64'(s1), 64'h0);
    check("w1_cout", 64'(co1), 64'd1);
`ifdef MWADD_FLAGS_EN
    check("w1_zero", 64'(z1), 64'd1);
    check("w1_ovf", 64'(of1), 64'd0);
`endif
    @(posedge clk);
    #1;
    @(negedge clk);
    a1 = 16'h1234;
    b1 = 16'h4321;
    c1 = 1'b1;
    v1 = 1'b1;
    @(posedge clk);
    #1;
    v1     = 1'b0;
    cycles = 0;
    while (ov1 !== 1'b1 && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("w1b_latency", 64'(cycles), 64'd1);
    check("w1b_sum", 64'(s1), 64'h5556);
    check("w1b_cout", 64'(co1), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
